// File: rtl/operand_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : operand_tile_pkg
// Brief   : Shared types and helpers for the operand tile loader.
// Revision: 1.0
// ============================================================================
package operand_tile_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } loader_state_t;

    // Index width for an n-entry dimension; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module  : operand_tile_buffer
// Brief   : NxN element store, row-write port, column or row read at index.
// Revision: 1.0
// ============================================================================
module operand_tile_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int N           = 4,
    parameter int IDX_BITS    = 2,
    parameter bit READ_COLUMN = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [IDX_BITS-1:0]          wr_row,
    input  logic [N-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_BITS-1:0]          rd_idx,
    output logic [N-1:0][DATA_WIDTH-1:0] rd_data
);

    logic [N-1:0][DATA_WIDTH-1:0] r_mem [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_row] <= wr_data;
        end
    end

    generate
        if (READ_COLUMN) begin : g_col_read
            // A side: element i of the beat is A[i][k].
            for (genvar i = 0; i < N; i++) begin : g_elem
                assign rd_data[i] = r_mem[i][rd_idx];
            end
        end else begin : g_row_read
            assign rd_data = r_mem[rd_idx];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/operand_tile_loader.sv
`default_nettype none
// ============================================================================
// Module  : operand_tile_loader
// Brief   : Loads A/B tiles row by row, then streams N column/row beats.
// Revision: 1.0
// ============================================================================
module operand_tile_loader
    import operand_tile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int IDX_BITS   = idx_bits(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic                         load_sel,
    input  logic [IDX_BITS-1:0]          load_row,
    input  logic [N-1:0][DATA_WIDTH-1:0] load_data,
    output logic [N-1:0][DATA_WIDTH-1:0] a_data,
    output logic [N-1:0][DATA_WIDTH-1:0] b_data,
    output logic                         a_valid,
    output logic                         b_valid,
    output logic                         last,
    input  logic                         stream_ready,
    output logic                         busy
);

    localparam logic [IDX_BITS:0]   c_N      = (IDX_BITS + 1)'(N);
    localparam logic [IDX_BITS-1:0] c_K_LAST = IDX_BITS'(N - 1);

    loader_state_t       r_state, w_state_nxt;
    logic [N-1:0]        r_a_mask, w_a_mask_nxt;
    logic [N-1:0]        r_b_mask, w_b_mask_nxt;
    logic [IDX_BITS-1:0] r_k, w_k_nxt;

    logic                         w_row_ok;
    logic                         w_a_wr;
    logic                         w_b_wr;
    logic [N-1:0]                 w_row_bit;
    logic [N-1:0][DATA_WIDTH-1:0] w_a_col;
    logic [N-1:0][DATA_WIDTH-1:0] w_b_row;

    // Writes happen only in LOAD, so the buffers are frozen while streaming.
    assign w_row_ok  = ({1'b0, load_row} < c_N);
    assign w_a_wr    = load_valid && (r_state == LOAD) && !load_sel && w_row_ok;
    assign w_b_wr    = load_valid && (r_state == LOAD) &&  load_sel && w_row_ok;
    assign w_row_bit = N'(1) << load_row;

    operand_tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_BITS   (IDX_BITS),
        .READ_COLUMN(1'b1)
    ) u_a_buf (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (w_a_wr),
        .wr_row (load_row),
        .wr_data(load_data),
        .rd_idx (r_k),
        .rd_data(w_a_col)
    );

    operand_tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_BITS   (IDX_BITS),
        .READ_COLUMN(1'b0)
    ) u_b_buf (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (w_b_wr),
        .wr_row (load_row),
        .wr_data(load_data),
        .rd_idx (r_k),
        .rd_data(w_b_row)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= LOAD;
            r_a_mask <= '0;
            r_b_mask <= '0;
            r_k      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a_mask <= w_a_mask_nxt;
            r_b_mask <= w_b_mask_nxt;
            r_k      <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_mask_nxt = r_a_mask;
        w_b_mask_nxt = r_b_mask;
        w_k_nxt      = r_k;
        load_ready   = 1'b0;
        a_valid      = 1'b0;
        b_valid      = 1'b0;
        last         = 1'b0;
        busy         = 1'b0;
        a_data       = '0;
        b_data       = '0;

        case (r_state)
            LOAD: begin
                load_ready = 1'b1;
                if (w_a_wr) w_a_mask_nxt = r_a_mask | w_row_bit;
                if (w_b_wr) w_b_mask_nxt = r_b_mask | w_row_bit;
                if ((w_a_wr || w_b_wr) && (&w_a_mask_nxt) && (&w_b_mask_nxt)) begin
                    w_state_nxt = STREAM;
                    w_k_nxt     = '0;
                end
            end
            STREAM: begin
                // Valids depend on state only; the engine's ready is built from them.
                a_valid = 1'b1;
                b_valid = 1'b1;
                busy    = 1'b1;
                last    = (r_k == c_K_LAST);
                a_data  = w_a_col;
                b_data  = w_b_row;
                if (stream_ready) begin
                    if (r_k == c_K_LAST) begin
                        w_state_nxt  = LOAD;
                        w_a_mask_nxt = '0;
                        w_b_mask_nxt = '0;
                        w_k_nxt      = '0;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_tile_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_tile_loader
// Brief   : Directed self-checking bench for operand_tile_loader.
// Revision: 1.0
// ============================================================================
module tb_operand_tile_loader;

    localparam int DW = 8;
    localparam int N  = 4;

    logic                 clk;
    logic                 reset;
    logic                 load_valid;
    logic                 load_ready;
    logic                 load_sel;
    logic [1:0]           load_row;
    logic [N-1:0][DW-1:0] load_data;
    logic [N-1:0][DW-1:0] a_data;
    logic [N-1:0][DW-1:0] b_data;
    logic                 a_valid;
    logic                 b_valid;
    logic                 last;
    logic                 stream_ready;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mat_a [N][N];
    logic [DW-1:0] mat_b [N][N];

    operand_tile_loader #(
        .DATA_WIDTH(DW),
        .N         (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_sel    (load_sel),
        .load_row    (load_row),
        .load_data   (load_data),
        .a_data      (a_data),
        .b_data      (b_data),
        .a_valid     (a_valid),
        .b_valid     (b_valid),
        .last        (last),
        .stream_ready(stream_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0][DW-1:0] exp_a(input int k);
        logic [N-1:0][DW-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mat_a[i][k];
        return v;
    endfunction

    function automatic logic [N-1:0][DW-1:0] exp_b(input int k);
        logic [N-1:0][DW-1:0] v;
        for (int j = 0; j < N; j++) v[j] = mat_b[k][j];
        return v;
    endfunction

    function automatic logic [N-1:0][DW-1:0] row_of(input logic sel, input int r);
        logic [N-1:0][DW-1:0] v;
        for (int j = 0; j < N; j++) v[j] = sel ? mat_b[r][j] : mat_a[r][j];
        return v;
    endfunction

    task automatic set_default_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = 8'(4 * i + j + 1);
                mat_b[i][j] = 8'(16 + 4 * i + j);
            end
    endtask

    // Presents one row for one cycle; returns at posedge+1 after the edge.
    task automatic do_load(input logic sel, input int r, input logic [N-1:0][DW-1:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_row   = 2'(r);
        load_data  = d;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            do_load(1'b0, i, row_of(1'b0, i));
            do_load(1'b1, i, row_of(1'b1, i));
        end
    endtask

    task automatic drain();
        stream_ready = 1'b1;
        repeat (N) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (load_ready !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0 ||
            last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b av=%b bv=%b last=%b busy=%b, want 1 0 0 0 0",
                     load_ready, a_valid, b_valid, last, busy);
        end
        checks++;
        if (a_data !== '0 || b_data !== '0) begin
            failures++;
            $display("FAIL reset_data: got a=%h b=%h, want 0", a_data, b_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        set_default_mats();
        stream_ready = 1'b1;
        load_all();
        checks++;
        if (a_data !== {8'd13, 8'd9, 8'd5, 8'd1} || b_data !== {8'd19, 8'd18, 8'd17, 8'd16}) begin
            failures++;
            $display("FAIL basic_beat0: got a=%h b=%h, want a=0d090501 b=13121110", a_data, b_data);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (a_valid !== 1'b1 || b_valid !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0 ||
                last !== (k == N - 1) || a_data !== exp_a(k) || b_data !== exp_b(k)) begin
                failures++;
                $display("FAIL basic_beat%0d: got v=%b%b busy=%b rdy=%b last=%b a=%h b=%h, want a=%h b=%h last=%b",
                         k, a_valid, b_valid, busy, load_ready, last, a_data, b_data,
                         exp_a(k), exp_b(k), (k == N - 1));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (load_ready !== 1'b1 || a_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: got rdy=%b av=%b busy=%b, want 1 0 0", load_ready, a_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        set_default_mats();
        stream_ready = 1'b1;
        load_all();
        repeat (2) begin
            @(posedge clk); #1;
        end
        stream_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (a_valid !== 1'b1 || last !== 1'b0 || a_data !== exp_a(2) || b_data !== exp_b(2)) begin
                failures++;
                $display("FAIL bp_hold%0d: got av=%b last=%b a=%h b=%h, want 1 0 a=%h b=%h",
                         c, a_valid, last, a_data, b_data, exp_a(2), exp_b(2));
            end
        end
        stream_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_valid !== 1'b1 || last !== 1'b1 || a_data !== exp_a(3) || b_data !== exp_b(3)) begin
            failures++;
            $display("FAIL bp_beat3: got av=%b last=%b a=%h b=%h, want 1 1 a=%h b=%h",
                     a_valid, last, a_data, b_data, exp_a(3), exp_b(3));
        end
        @(posedge clk); #1;
        checks++;
        if (load_ready !== 1'b1 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: got rdy=%b av=%b, want 1 0", load_ready, a_valid);
        end
    endtask

    task automatic test_incomplete();
        int bad;
        set_default_mats();
        stream_ready = 1'b1;
        for (int i = 0; i < N; i++) do_load(1'b0, i, row_of(1'b0, i));
        for (int i = 0; i < N - 1; i++) do_load(1'b1, i, row_of(1'b1, i));
        bad = 0;
        repeat (10) begin
            if (a_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL incomplete_idle: got a_valid high in %0d cycles, want 0", bad);
        end
        do_load(1'b1, N - 1, row_of(1'b1, N - 1));
        checks++;
        if (a_valid !== 1'b1 || a_data !== exp_a(0) || b_data !== exp_b(0)) begin
            failures++;
            $display("FAIL incomplete_go: got av=%b a=%h b=%h, want 1 a=%h b=%h",
                     a_valid, a_data, b_data, exp_a(0), exp_b(0));
        end
        drain();
    endtask

    task automatic test_overwrite();
        set_default_mats();
        stream_ready = 1'b0;
        do_load(1'b0, 1, {8'd9, 8'd9, 8'd9, 8'd9});
        do_load(1'b0, 1, {8'd5, 8'd4, 8'd3, 8'd2});
        mat_a[1][0] = 8'd2; mat_a[1][1] = 8'd3; mat_a[1][2] = 8'd4; mat_a[1][3] = 8'd5;
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovw_mask: got a_valid=%b after rewrites, want 0", a_valid);
        end
        for (int i = 0; i < N; i++) begin
            if (i != 1) do_load(1'b0, i, row_of(1'b0, i));
            do_load(1'b1, i, row_of(1'b1, i));
        end
        stream_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_data[1] !== 8'd3 || a_data !== exp_a(1)) begin
            failures++;
            $display("FAIL ovw_beat1: got a=%h a[1]=%0d, want a=%h a[1]=3", a_data, a_data[1], exp_a(1));
        end
        repeat (N - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_ignored();
        int bad;
        set_default_mats();
        stream_ready = 1'b1;
        load_all();
        bad = 0;
        for (int k = 0; k < N; k++) begin
            load_valid = 1'b1;
            load_sel   = k[0];
            load_row   = 2'(k);
            load_data  = {4{8'hAA}};
            #1;
            if (load_ready !== 1'b0 || a_data !== exp_a(k) || b_data !== exp_b(k)) bad++;
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ignore_stream: got %0d bad beats, want 0", bad);
        end
        checks++;
        if (a_valid !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL ignore_done: got av=%b rdy=%b, want 0 1", a_valid, load_ready);
        end
    endtask

    task automatic test_async_reset();
        set_default_mats();
        stream_ready = 1'b1;
        load_all();
        @(posedge clk); #1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 ||
            load_ready !== 1'b1 || a_data !== '0) begin
            failures++;
            $display("FAIL areset_now: got av=%b bv=%b last=%b busy=%b rdy=%b a=%h, want 0 0 0 0 1 0",
                     a_valid, b_valid, last, busy, load_ready, a_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (load_ready !== 1'b1 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_release: got rdy=%b av=%b, want 1 0", load_ready, a_valid);
        end
        for (int i = 0; i < N; i++) do_load(1'b0, i, row_of(1'b0, i));
        for (int i = 0; i < N - 1; i++) do_load(1'b1, i, row_of(1'b1, i));
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_partial: got a_valid=%b, want 0", a_valid);
        end
        do_load(1'b1, N - 1, row_of(1'b1, N - 1));
        checks++;
        if (a_valid !== 1'b1 || a_data !== exp_a(0) || b_data !== exp_b(0)) begin
            failures++;
            $display("FAIL areset_reload: got av=%b a=%h b=%h, want 1 a=%h b=%h",
                     a_valid, a_data, b_data, exp_a(0), exp_b(0));
        end
        drain();
    endtask

    initial begin
        load_valid   = 1'b0;
        load_sel     = 1'b0;
        load_row     = '0;
        load_data    = '0;
        stream_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_incomplete();
        test_overwrite();
        test_load_ignored();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_tile_loader.md
# operand_tile_loader

Upstream feeder for the sum-stationary systolic engine. Captures an NxN A tile and an NxN B tile row by row over a valid/ready load port. Once both tiles are complete, streams them as N beats: column k of A and row k of B per beat, with `last` on beat N-1. The stream port connects directly to the engine's `a_data`/`b_data`/`a_input_valid`/`b_input_valid`/`input_ready`/`last` pins.

## Interface
- DATA_WIDTH, 8, element width
- N, 4, tile side length
- IDX_BITS, $clog2(N), row/beat index width

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  load row presented
- load_ready  out  1  loader accepts a row
- load_sel  in  1  0 = A tile, 1 = B tile
- load_row  in  IDX_BITS  destination row index
- load_data  in  DATA_WIDTH x N  row elements; element j goes to column j
- a_data  out  DATA_WIDTH x N  a_data[i] = A[i][k]
- b_data  out  DATA_WIDTH x N  b_data[j] = B[k][j]
- a_valid  out  1  stream beat valid (A side)
- b_valid  out  1  stream beat valid (B side); always equal to a_valid
- last  out  1  high with beat k = N-1 only
- stream_ready  in  1  downstream accepts the current beat
- busy  out  1  high in STREAM

## Operation
- The FSM has two states, LOAD and STREAM. Reset enters LOAD.
- LOAD:
  - load_ready = 1; a_valid = b_valid = last = 0; a_data and b_data are driven to '0.
  - A load fires when load_valid && load_ready. It writes load_data into row load_row of the selected tile and sets the matching bit in that tile's written mask (a_mask or b_mask, N bits each).
  - Rewriting a row already written overwrites the data. The mask is unchanged.
  - Out-of-range load_row (N not a power of 2) is ignored: no write, no mask change.
  - The load that makes both masks all-ones moves the FSM to STREAM on the same edge, with beat counter k = 0.
- STREAM:
  - load_ready = 0, so load_valid is ignored and the buffers are frozen.
  - a_valid = b_valid = 1. Data is read combinationally from the buffers at index k. last = (k == N-1).
  - A beat fires when stream_ready is high. A fire with k < N-1 increments k.
  - A fire with last high clears both masks, resets k to 0 and returns the FSM to LOAD. The buffer contents are retained.
  - With stream_ready low, all outputs hold and k does not change.
- Valid outputs depend on state only, never on stream_ready. This is required because the downstream input_ready is combinational on valid.
- Reset at any time, including mid-stream, immediately forces LOAD. Masks, k and the buffers go to 0. Partial streams are dropped, with no `last`.
- Reset values of outputs: load_ready = 1, a_valid = b_valid = last = busy = 0, a_data = b_data = '0.

## Timing
- Load port: 1 row per cycle. At least 2N load cycles per tile pair.
- Completing load at edge t gives a_valid high during cycle t+1. First-beat latency is 1 cycle.
- Stream port with stream_ready held high: N consecutive beats, one per cycle. `last` appears in the N-th valid cycle.
- After the final beat fires at edge t, load_ready is high in cycle t+1.
- No load and stream overlap: the block is single-buffered.

## Structure
- Package `operand_tile_pkg`:
  - `typedef enum logic {LOAD, STREAM} loader_state_t`
  - IDX_BITS helper
- Sub-module `operand_tile_buffer`, instantiated twice:
  - NxN register array with a row-write port, reset to 0.
  - Parameter READ_COLUMN selects a column read (A) or a row read (B) at index k.
- Top level holds the FSM, both masks and the beat counter k.

## Test plan
- Basic stream:
  - Stimulus: load A[i][j] = 4i+j+1 and B[i][j] = 16+4i+j in interleaved row order, with stream_ready = 1.
  - Response on beat 0: a_data = {1,5,9,13}, b_data = {16,17,18,19}.
  - Response on beat 3: a_data = {4,8,12,16}, b_data = {28,29,30,31}, last = 1.
  - Then load_ready = 1 on the next cycle.
- Backpressure:
  - Stimulus: stream_ready low for 3 cycles at beat 2.
  - Response: a_data and b_data hold column/row 2, last = 0, and a 4th beat follows once stream_ready rises.
- Incomplete tile:
  - Stimulus: write all A rows and B rows 0-2 only.
  - Response: a_valid stays 0 indefinitely.
  - Then writing B row 3 gives a_valid = 1 on the next cycle.
- Overwrite:
  - Stimulus: write A row 1 = {9,9,9,9}, then A row 1 = {2,3,4,5}, then complete both tiles.
  - Response: on beat 1, a_data[1] = 3.
- Load ignored in STREAM:
  - Stimulus: hold load_valid with new data during all beats.
  - Response: load_ready = 0 and the streamed values are unchanged.
- Async reset mid-stream:
  - Stimulus: assert reset low between edges at beat 1.
  - Response: a_valid, last and busy go to 0 immediately. load_ready = 1 after release. A fresh full load is needed before a_valid reasserts.
